bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 16-bit datapath bus. Up to `N_REQ` bus drivers (PC, MDR, ALU, MARMUX gates) request the bus. The block grants exactly one at a time, drives the bus mux select and one-hot gate enables, and forwards the winner's data. It inserts one dead cycle between owners and bounds each tenure so no driver can starve the others.

---
 rtl/bus_arbiter.sv | 109 ++++++++++
 tb/tb_bus_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one-cycle turnaround and bounded tenure.
// Forwards the owner's data onto the shared datapath bus.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           done,
    input  logic [N_REQ*WIDTH-1:0]     data_in,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   gate_sel,
    output logic                       bus_valid,
    output logic [WIDTH-1:0]           bus_out,
    output logic                       preempt
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   last, last_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            pre_q, pre_n;

    logic            any_win;
    logic [IW-1:0]   win;
    logic [N_REQ-1:0] own_oh;
    logic            others;
    logic            release_r;
    logic            tmo;
    logic            at_max;

    // Round-robin search starting just after the most recent owner.
    always_comb begin
        any_win = 1'b0;
        win     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!any_win && req[(int'(last) + k) % N_REQ]) begin
                any_win = 1'b1;
                win     = IW'((int'(last) + k) % N_REQ);
            end
        end
    end

    assign own_oh    = N_REQ'(1) << last;
    assign others    = |(req & ~own_oh);
    assign release_r = !req[last] || done[last];
    assign at_max    = (cnt == CW'(MAX_HOLD - 1));
    assign tmo       = at_max && others;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            last  <= IW'(N_REQ - 1);
            cnt   <= '0;
            pre_q <= 1'b0;
        end else begin
            state <= state_n;
            last  <= last_n;
            cnt   <= cnt_n;
            pre_q <= pre_n;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        pre_n   = 1'b0;
        unique case (state)
            IDLE, TURN: begin
                if (any_win) begin
                    state_n = GRANT;
                    last_n  = win;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (release_r) begin
                    state_n = TURN;
                end else if (tmo) begin
                    state_n = TURN;
                    pre_n   = 1'b1;
                end else if (!at_max) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus_valid = (state == GRANT);
    assign grant     = bus_valid ? own_oh : '0;
    assign gate_sel  = bus_valid ? last : '0;
    assign bus_out   = bus_valid ? data_in[int'(last)*WIDTH +: WIDTH] : '0;
    assign preempt   = pre_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, rotation, timeout,
// uncontended hold, ignored strobes and async reset.
module tb_bus_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [63:0] data_in;
    logic [3:0]  grant;
    logic [1:0]  gate_sel;
    logic        bus_valid;
    logic [15:0] bus_out;
    logic        preempt;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .N_REQ    (4),
        .WIDTH    (16),
        .MAX_HOLD (8)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .done      (done),
        .data_in   (data_in),
        .grant     (grant),
        .gate_sel  (gate_sel),
        .bus_valid (bus_valid),
        .bus_out   (bus_out),
        .preempt   (preempt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_valid"}, 32'(bus_valid), 32'h0);
        chk({tag, "_bus"}, 32'(bus_out), 32'h0);
    endtask

    logic [15:0] dv [4];

    initial begin
        dv[0] = 16'h1111;
        dv[1] = 16'h2222;
        dv[2] = 16'hBEEF;
        dv[3] = 16'h4444;
        data_in = {dv[3], dv[2], dv[1], dv[0]};
        Reset_n = 1'b0;
        req     = 4'b1111;
        done    = 4'b0000;

        // Reset held with all requests up
        tick();
        tick();
        chk_idle("rst");
        chk("rst_sel", 32'(gate_sel), 32'h0);
        chk("rst_pre", 32'(preempt), 32'h0);

        Reset_n = 1'b1;
        tick();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_sel", 32'(gate_sel), 32'h0);
        chk("first_bus", 32'(bus_out), 32'h1111);

        // Rotation 0 -> 1 -> 2 -> 3 -> 0, each releasing via done
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_hold", 32'(grant), 32'(4'b0001 << i));
            chk("rr_sel", 32'(gate_sel), 32'(i));
            chk("rr_bus", 32'(bus_out), 32'(dv[i]));
            done = 4'b0001 << i;
            tick();
            done = 4'b0000;
            chk_idle("rr_turn");
            tick();
            chk("rr_next", 32'(grant), 32'(4'b0001 << ((i + 1) % 4)));
        end

        // Timeout: owner 0 holds 8 cycles against requester 1
        req = 4'b0011;
        for (int c = 1; c < 8; c++) begin
            tick();
            chk("to_hold", 32'(grant), 32'h1);
            chk("to_nopre", 32'(preempt), 32'h0);
        end
        tick();
        chk("to_turn", 32'(grant), 32'h0);
        chk("to_pre", 32'(preempt), 32'h1);
        tick();
        chk("to_next", 32'(grant), 32'h2);
        chk("to_preclr", 32'(preempt), 32'h0);

        // Owner 1 drops its request; only requester 2 remains
        req = 4'b0100;
        tick();
        chk_idle("nc_turn");
        tick();
        chk("nc_grant", 32'(grant), 32'h4);
        chk("nc_sel", 32'(gate_sel), 32'h2);
        chk("nc_bus", 32'(bus_out), 32'hBEEF);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("nc_hold", 32'(grant), 32'h4);
            chk("nc_nopre", 32'(preempt), 32'h0);
        end
        data_in[47:32] = 16'hCAFE;
        #1;
        chk("nc_track", 32'(bus_out), 32'hCAFE);

        // Non-owner done ignored
        done = 4'b1011;
        tick();
        chk("ev_nonown", 32'(grant), 32'h4);
        // Owner drops req and strobes done together
        done = 4'b0100;
        req  = 4'b0000;
        tick();
        done = 4'b0000;
        chk_idle("ev_turn");
        chk("ev_nopre", 32'(preempt), 32'h0);
        tick();
        chk_idle("ev_idle");
        tick();
        chk_idle("ev_idle2");

        // Async reset mid-tenure
        req = 4'b0010;
        tick();
        chk("ar_grant", 32'(grant), 32'h2);
        req = 4'b1111;
        #2;
        Reset_n = 1'b0;
        #1;
        chk_idle("ar_async");
        chk("ar_sel", 32'(gate_sel), 32'h0);
        #1;
        Reset_n = 1'b1;
        tick();
        chk("ar_first", 32'(grant), 32'h1);
        chk("ar_bus", 32'(bus_out), 32'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
